// File: rtl/lsu.sv
// Load/store unit: one outstanding request/grant transaction on the data-memory port.
// It steers store lanes and builds strobes, and it extracts and extends load lanes.
//
// state  | meaning
// S_IDLE | ready; checks a presented op and either faults or captures it
// S_REQ  | mem_req held with stable address/data until mem_gnt
// S_WAIT | load granted; waiting for mem_rvalid
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic [4:0]  ex_rd,
  output logic        lsu_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lsu_fault,
  output logic [31:0] fault_addr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        busy_q, busy_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [4:0]  rd_q, rd_d;

  logic [1:0]  off;
  logic        bad_op;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] rsh;
  logic [31:0] ld_data;

  assign off = ex_addr[1:0];

  always_comb begin
    bad_op = 1'b0;
    if (ex_load == ex_store) bad_op = 1'b1;
    if (ex_funct3 == 3'b011 || ex_funct3 == 3'b110 || ex_funct3 == 3'b111) bad_op = 1'b1;
    if (ex_store && ex_funct3[2]) bad_op = 1'b1;
    if (ex_funct3[1:0] == 2'b01 && off[0]) bad_op = 1'b1;
    if (ex_funct3[1:0] == 2'b10 && off != 2'b00) bad_op = 1'b1;
  end

  always_comb begin
    st_wdata = ex_wdata;
    st_wstrb = 4'b1111;
    case (ex_funct3[1:0])
      2'b00: begin
        st_wdata = {4{ex_wdata[7:0]}};
        st_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        st_wdata = {2{ex_wdata[15:0]}};
        st_wstrb = 4'b0011 << off;
      end
      default: begin
        st_wdata = ex_wdata;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Word loads are always aligned, so the shifted word equals the raw word for them.
  always_comb begin
    rsh = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_data = {{24{rsh[7]}}, rsh[7:0]};
      3'b100:  ld_data = {24'd0, rsh[7:0]};
      3'b001:  ld_data = {{16{rsh[15]}}, rsh[15:0]};
      3'b101:  ld_data = {16'd0, rsh[15:0]};
      default: ld_data = rsh;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    wb_valid_d   = 1'b0;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    fault_d      = 1'b0;
    fault_addr_d = fault_addr_q;
    f3_d         = f3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          if (bad_op) begin
            fault_d      = 1'b1;
            fault_addr_d = ex_addr;
          end else begin
            state_d     = S_REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = ex_store;
            mem_addr_d  = {ex_addr[31:2], 2'b00};
            mem_wdata_d = ex_store ? st_wdata : 32'd0;
            mem_wstrb_d = ex_store ? st_wstrb : 4'b0000;
            f3_d        = ex_funct3;
            off_d       = off;
            rd_d        = ex_rd;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          wb_valid_d = 1'b1;
          wb_data_d  = ld_data;
          wb_rd_d    = rd_q;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_wdata_q  <= 32'd0;
      mem_wstrb_q  <= 4'd0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= 5'd0;
      wb_data_q    <= 32'd0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      rd_q         <= 5'd0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      wb_valid_q   <= wb_valid_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
    end
  end

  assign lsu_busy   = busy_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign lsu_fault  = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table applied through a scoreboard queue,
// plus hand sequences for back-to-back faults and reset during a pending load.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_fault;
  logic [31:0] fault_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_busy(lsu_busy), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lsu_fault(lsu_fault), .fault_addr(fault_addr)
  );

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_dly;
    int          rv_dly;
    logic        spur;
    logic        exp_fault;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b000;
    ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
  endtask

  task automatic add(input string name, input logic ld, input logic st, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                     input logic [31:0] rdata, input int gd, input int rv, input logic spur,
                     input logic ef, input logic [31:0] ema, input logic [31:0] emw,
                     input logic [3:0] ews, input logic [31:0] ewb);
    vec_t v;
    v.name = name; v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rd = rd; v.rdata = rdata; v.gnt_dly = gd; v.rv_dly = rv; v.spur = spur;
    v.exp_fault = ef; v.exp_maddr = ema; v.exp_mwdata = emw; v.exp_wstrb = ews; v.exp_wb = ewb;
    vecs.push_back(v);
  endtask

  // Drive one op at a negedge, then walk it through grant/response, checking at negedges.
  task automatic run_vec(input vec_t v);
    vec_t e;
    exp_q.push_back(v);
    @(negedge clk);
    ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st; ex_funct3 = v.f3;
    ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
    @(negedge clk);
    ex_valid = 1'b0;
    e = exp_q.pop_front();
    if (e.exp_fault) begin
      check({e.name, " fault"}, {31'd0, lsu_fault}, 32'd1);
      check({e.name, " fault_addr"}, fault_addr, e.addr);
      check({e.name, " no req"}, {31'd0, mem_req}, 32'd0);
      check({e.name, " not busy"}, {31'd0, lsu_busy}, 32'd0);
      @(negedge clk);
      check({e.name, " fault pulse"}, {31'd0, lsu_fault}, 32'd0);
      check({e.name, " still no req"}, {31'd0, mem_req}, 32'd0);
      return;
    end
    check({e.name, " req"}, {31'd0, mem_req}, 32'd1);
    check({e.name, " busy"}, {31'd0, lsu_busy}, 32'd1);
    check({e.name, " we"}, {31'd0, mem_we}, {31'd0, e.st});
    check({e.name, " addr"}, mem_addr, e.exp_maddr);
    check({e.name, " wstrb"}, {28'd0, mem_wstrb}, {28'd0, e.exp_wstrb});
    if (e.st) check({e.name, " wdata"}, mem_wdata, e.exp_mwdata);
    // While waiting for grant: offer a bad op that must be ignored, optionally spurious rvalid.
    for (int i = 0; i < e.gnt_dly; i++) begin
      ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
      ex_addr = 32'hFFFF_FFF1;
      mem_rvalid = e.spur; mem_rdata = 32'hA5A5_5A5A;
      @(negedge clk);
      check({e.name, " req held"}, {31'd0, mem_req}, 32'd1);
      check({e.name, " addr held"}, mem_addr, e.exp_maddr);
      check({e.name, " no fault busy"}, {31'd0, lsu_fault}, 32'd0);
      check({e.name, " no wb in req"}, {31'd0, wb_valid}, 32'd0);
    end
    ex_valid = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = e.spur; mem_rdata = 32'hA5A5_5A5A;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    check({e.name, " req drop"}, {31'd0, mem_req}, 32'd0);
    check({e.name, " no wb after gnt"}, {31'd0, wb_valid}, 32'd0);
    if (e.st) begin
      check({e.name, " store done"}, {31'd0, lsu_busy}, 32'd0);
      return;
    end
    check({e.name, " busy wait"}, {31'd0, lsu_busy}, 32'd1);
    for (int i = 0; i < e.rv_dly; i++) begin
      @(negedge clk);
      check({e.name, " busy rv wait"}, {31'd0, lsu_busy}, 32'd1);
      check({e.name, " no early wb"}, {31'd0, wb_valid}, 32'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = e.rdata;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    check({e.name, " wb_valid"}, {31'd0, wb_valid}, 32'd1);
    check({e.name, " wb_data"}, wb_data, e.exp_wb);
    check({e.name, " wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
    check({e.name, " idle at wb"}, {31'd0, lsu_busy}, 32'd0);
    @(negedge clk);
    check({e.name, " wb pulse"}, {31'd0, wb_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //   name     ld st f3      addr          wdata         rd rdata         gd rv sp flt maddr         mwdata        wstrb    wb
    add("SW mis", 0, 1, 3'b010, 32'h1000_0006, 32'h1111_2222, 0, 32'h0,       0, 0, 0, 1, 32'h0,       32'h0,        4'b0000, 32'h0);
    add("SB",     0, 1, 3'b000, 32'h0000_2003, 32'h1234_56AB, 0, 32'h0,       0, 0, 0, 0, 32'h2000,    32'hABAB_ABAB, 4'b1000, 32'h0);
    add("LH",     1, 0, 3'b001, 32'h0000_0042, 32'h0,        5, 32'h8001_7FFF, 0, 0, 0, 0, 32'h40,      32'h0,        4'b0000, 32'hFFFF_8001);
    add("LHU",    1, 0, 3'b101, 32'h0000_0042, 32'h0,        6, 32'h8001_7FFF, 0, 0, 0, 0, 32'h40,      32'h0,        4'b0000, 32'h0000_8001);
    add("LB dly", 1, 0, 3'b000, 32'h0000_0101, 32'h0,        9, 32'h0000_F000, 3, 2, 0, 0, 32'h100,     32'h0,        4'b0000, 32'hFFFF_FFF0);
    add("LW spur",1, 0, 3'b010, 32'h0000_0200, 32'h0,       31, 32'hDEAD_BEEF, 2, 1, 1, 0, 32'h200,     32'h0,        4'b0000, 32'hDEAD_BEEF);
    add("SH",     0, 1, 3'b001, 32'h0000_0302, 32'hCAFE_1234, 0, 32'h0,       1, 0, 0, 0, 32'h300,     32'h1234_1234, 4'b1100, 32'h0);
    add("SW",     0, 1, 3'b010, 32'h0000_0404, 32'h89AB_CDEF, 0, 32'h0,       0, 0, 0, 0, 32'h404,     32'h89AB_CDEF, 4'b1111, 32'h0);
    add("LBU",    1, 0, 3'b100, 32'h0000_0503, 32'h0,        3, 32'h80FF_0011, 0, 0, 0, 0, 32'h500,     32'h0,        4'b0000, 32'h0000_0080);
    add("LH odd", 1, 0, 3'b001, 32'h0000_0601, 32'h0,        4, 32'h0,        0, 0, 0, 1, 32'h0,       32'h0,        4'b0000, 32'h0);
    add("SBU",    0, 1, 3'b100, 32'h0000_0700, 32'h0,        0, 32'h0,        0, 0, 0, 1, 32'h0,       32'h0,        4'b0000, 32'h0);
    add("f3 011", 1, 0, 3'b011, 32'h0000_0800, 32'h0,        2, 32'h0,        0, 0, 0, 1, 32'h0,       32'h0,        4'b0000, 32'h0);
    add("ld+st",  1, 1, 3'b000, 32'h0000_0900, 32'h0,        2, 32'h0,        0, 0, 0, 1, 32'h0,       32'h0,        4'b0000, 32'h0);
    add("SB off0",0, 1, 3'b000, 32'h0000_1000, 32'h0000_0055, 0, 32'h0,       0, 0, 0, 0, 32'h1000,    32'h5555_5555, 4'b0001, 32'h0);
    add("LB pos", 1, 0, 3'b000, 32'h0000_0002, 32'h0,        1, 32'h007F_0000, 1, 0, 0, 0, 32'h0,       32'h0,        4'b0000, 32'h0000_007F);

    idle_inputs();
    rst_n = 1'b0;
    #12;
    check("reset req", {31'd0, mem_req}, 32'd0);
    check("reset busy", {31'd0, lsu_busy}, 32'd0);
    check("reset wb_valid", {31'd0, wb_valid}, 32'd0);
    check("reset fault", {31'd0, lsu_fault}, 32'd0);
    check("reset addr", mem_addr, 32'd0);
    check("reset wdata", mem_wdata, 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    check("reset fault_addr", fault_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back faults pulse every cycle with the latest address.
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 32'h0000_0A01;
    @(negedge clk);
    ex_addr = 32'h0000_0B02;
    check("b2b fault 1", {31'd0, lsu_fault}, 32'd1);
    check("b2b addr 1", fault_addr, 32'h0000_0A01);
    @(negedge clk);
    ex_valid = 1'b0;
    check("b2b fault 2", {31'd0, lsu_fault}, 32'd1);
    check("b2b addr 2", fault_addr, 32'h0000_0B02);
    check("b2b no busy", {31'd0, lsu_busy}, 32'd0);
    @(negedge clk);
    check("b2b pulse end", {31'd0, lsu_fault}, 32'd0);

    // Reset while a load waits for data: abandoned, no late writeback.
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h0000_0080; ex_rd = 5'd7;
    @(negedge clk);
    ex_valid = 1'b0;
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rst pre busy", {31'd0, lsu_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst async req", {31'd0, mem_req}, 32'd0);
    check("rst async busy", {31'd0, lsu_busy}, 32'd0);
    check("rst async addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rst no wb", {31'd0, wb_valid}, 32'd0);
    check("rst still idle", {31'd0, lsu_busy}, 32'd0);
    begin
      vec_t v;
      v.name = "LW post rst"; v.ld = 1; v.st = 0; v.f3 = 3'b010; v.addr = 32'h0000_0084;
      v.wdata = 0; v.rd = 5'd12; v.rdata = 32'h0BAD_F00D; v.gnt_dly = 0; v.rv_dly = 0;
      v.spur = 0; v.exp_fault = 0; v.exp_maddr = 32'h84; v.exp_mwdata = 0;
      v.exp_wstrb = 4'b0000; v.exp_wb = 32'h0BAD_F00D;
      run_vec(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the execute-stage ALU: it takes the ALU `RESULT` as the effective address of a RISC-V load or store and runs a single outstanding transaction on a simple request/grant data-memory port. It performs byte-lane steering and write-strobe generation for stores, plus lane extraction and sign/zero extension for loads. It stalls the upstream pipeline while a transaction is in flight and flags misaligned or illegal accesses instead of issuing them.

## Interface
- No parameters; data and address width fixed at 32.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ex_valid`  in  1  memory op presented by execute stage.
- `ex_load` / `ex_store`  in  1 each  op type; exactly one high with `ex_valid`.
- `ex_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; 100/101 valid for loads only.
- `ex_addr`  in  32  effective address (ALU `RESULT`).
- `ex_wdata`  in  32  store data (rs2).
- `ex_rd`  in  5  load destination register.
- `lsu_busy`  out  1  transaction in flight; upstream must hold.
- `mem_req`  out  1  request valid.
- `mem_we`  out  1  1 = store.
- `mem_addr`  out  32  word address, bits [1:0] always 0.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_wstrb`  out  4  byte enables; 0000 on loads.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  load data valid.
- `mem_rdata`  in  32  load data word.
- `wb_valid`  out  1  one-cycle pulse, load result ready.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  32  extended load result.
- `lsu_fault`  out  1  one-cycle pulse, misaligned/illegal access.
- `fault_addr`  out  32  offending `ex_addr`.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: with `ex_valid`, the op is checked.
  - Fault conditions: H/HU with `ex_addr[0]`=1; W with `ex_addr[1:0]`≠0; funct3 011/110/111; BU/HU on a store; `ex_load`==`ex_store`.
  - On fault: no memory request, state stays IDLE, `lsu_fault`=1 and `fault_addr`=`ex_addr` next cycle.
  - Otherwise the op is captured and the state goes to REQ.
- REQ: `mem_req`=1 with `mem_addr`/`mem_we`/`mem_wdata`/`mem_wstrb` stable until `mem_gnt`.
  - On `mem_gnt`: store → IDLE; load → WAIT.
  - `mem_rvalid` seen in REQ is ignored.
- WAIT: on `mem_rvalid`, register `wb_data`/`wb_rd`, pulse `wb_valid`, go to IDLE.
- Offset off = `ex_addr[1:0]`.
- Store lanes:
  - B: `wdata` = {4{rs2[7:0]}}, `wstrb` = 0001<<off.
  - H: `wdata` = {2{rs2[15:0]}}, `wstrb` = 0011<<off.
  - W: `wdata` = rs2, `wstrb` = 1111.
- Load extraction:
  - B/BU: byte `rdata[8*off+7:8*off]`, sign-/zero-extended.
  - H/HU: half `rdata[8*off+15:8*off]`, sign-/zero-extended.
  - W: whole word.
- `lsu_busy` = (state ≠ IDLE). `ex_valid` while busy is ignored.
- All outputs are registered; `wb_valid` and `lsu_fault` are single-cycle pulses.

## Timing
- Reset (async, immediate): state IDLE, every output 0 (including `mem_req`, `wb_valid`, `lsu_fault`, all data/address outputs). Reset mid-transaction abandons it; no `wb_valid` follows.
- Accept at edge N: `mem_req` and `lsu_busy` high from cycle N+1.
- Store, `mem_gnt` in N+1: IDLE and `lsu_busy`=0 in N+2. Minimum store occupancy is 1 busy cycle.
- Load, `mem_gnt` in N+1, `mem_rvalid` in N+2: `wb_valid` in N+3 with `lsu_busy`=0. Minimum load latency is 3 cycles accept-to-writeback.
- `mem_rvalid` is accepted no earlier than the cycle after `mem_gnt`.
- In the `wb_valid` cycle the LSU is IDLE and may accept a new op the same cycle.
- Grant latency and read latency are unbounded; `lsu_busy` stays high for the whole wait.
- A fault in cycle N gives `lsu_fault` in N+1 with `lsu_busy` never asserted; back-to-back faults pulse every cycle.

## Test plan
- SW, `ex_addr`=0x1000_0006 → `lsu_fault`=1 next cycle, `fault_addr`=0x1000_0006, `mem_req` never high.
- SB rs2=0x1234_56AB, addr=0x2003, gnt immediate → `mem_addr`=0x2000, `mem_wdata`=0xABAB_ABAB, `mem_wstrb`=1000, `mem_we`=1; `lsu_busy` for 1 cycle.
- LH addr=0x40 offset 2, rdata=0x8001_7FFF → `wb_data`=0xFFFF_8001; LHU same → 0x0000_8001; `wb_rd` echoes `ex_rd`.
- LB addr offset 1, gnt delayed 3 cycles, rvalid delayed 2 more → `mem_req` and address stable until gnt, `wb_valid` 1 cycle after rvalid; rdata 0x0000_F000 → `wb_data`=0xFFFF_FFF0.
- Spurious `mem_rvalid` during REQ → ignored; only the post-gnt rvalid produces `wb_valid`.
- `rst_n` low while in WAIT → `mem_req`/`lsu_busy`=0 immediately; a later `mem_rvalid` produces no `wb_valid`; a new LW after reset completes normally.
